// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared FSM states, IR field indices and defaults for the Hack execution stage
package hack_pkg;

   localparam int PC_W_DEF = 15;

   // Instruction register field positions
   localparam int C_BIT    = 15;
   localparam int A_BIT    = 12;
   localparam int COMP_LSB = 6;
   localparam int DEST_A   = 5;
   localparam int DEST_D   = 4;
   localparam int DEST_M   = 3;
   localparam int JMP_LT   = 2;
   localparam int JMP_EQ   = 1;
   localparam int JMP_GT   = 0;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4,
      S_HALT   = 3'd5
   } exec_state_t;

   function automatic logic jump_taken(input logic [2:0] j, input logic ng, input logic zr);
      return (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_exec_unit_if.sv
// rtl/hack_exec_unit_if.sv - instruction fetch and data memory handshake bundle
interface hack_exec_unit_if #(
   parameter int PC_W = 15
) ();

   logic [PC_W-1:0] pc;
   logic [15:0]     instr;
   logic            instr_valid;
   logic            instr_ready;
   logic [PC_W-1:0] mem_addr;
   logic            mem_rd;
   logic [15:0]     mem_rdata;
   logic            mem_rd_valid;
   logic            mem_wr;
   logic [15:0]     mem_wdata;
   logic            mem_wr_ack;

   modport master (
      output pc, instr_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
      input  instr, instr_valid, mem_rdata, mem_rd_valid, mem_wr_ack
   );

   modport slave (
      input  pc, instr_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
      output instr, instr_valid, mem_rdata, mem_rd_valid, mem_wr_ack
   );

endinterface

// File: rtl/HackALU.sv
// rtl/HackALU.sv - combinational Hack ALU with zero and negative flags
module HackALU (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);

   logic [15:0] x0;
   logic [15:0] x1;
   logic [15:0] y0;
   logic [15:0] y1;
   logic [15:0] fo;

   assign x0  = zx ? 16'h0000 : x;
   assign x1  = nx ? ~x0 : x0;
   assign y0  = zy ? 16'h0000 : y;
   assign y1  = ny ? ~y0 : y0;
   assign fo  = f ? (x1 + y1) : (x1 & y1);
   assign out = no ? ~fo : fo;
   assign zr  = (out == 16'h0000);
   assign ng  = out[15];

endmodule

// File: rtl/Inc16.sv
// rtl/Inc16.sv - 16-bit incrementer, wraps on overflow
module Inc16 (
   input  logic [15:0] in,
   output logic [15:0] out
);

   assign out = in + 16'h0001;

endmodule

// File: rtl/hack_pc.sv
// rtl/hack_pc.sv - program counter register with load, increment and hold
module hack_pc
   import hack_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] load_val,
   input  logic [PC_W-1:0] inc_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q;

   // A jump load wins over the sequential increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= '0;
      end else if (load) begin
         pc_q <= load_val;
      end else if (inc) begin
         pc_q <= inc_val;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/hack_exec_unit.sv
// rtl/hack_exec_unit.sv - multi-cycle Hack execute stage; HACK_EXEC_STRICT_DECODE_EN halts on malformed C-instructions
module hack_exec_unit
   import hack_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   hack_exec_unit_if.master   bus,
   output logic [15:0]        a_reg,
   output logic [15:0]        d_reg,
   output logic               halted
);

   exec_state_t     state_q;
   exec_state_t     state_d;

   logic [15:0]     ir_q;
   logic [15:0]     a_q;
   logic [15:0]     d_q;
   logic [15:0]     m_q;
   logic [15:0]     wdata_q;
   logic [PC_W-1:0] addr_q;
   logic            jump_q;

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_next_inc;
   logic [PC_W-1:0] pc_target;
   logic            pc_load;
   logic            pc_inc;
   logic [15:0]     inc_out;

   logic [15:0]     alu_y;
   logic [15:0]     alu_out;
   logic            alu_zr;
   logic            alu_ng;
   logic            jump_now;
   logic            unused_inc;

   HackALU u_alu (
      .x   (d_q),
      .y   (alu_y),
      .zx  (ir_q[COMP_LSB+5]),
      .nx  (ir_q[COMP_LSB+4]),
      .zy  (ir_q[COMP_LSB+3]),
      .ny  (ir_q[COMP_LSB+2]),
      .f   (ir_q[COMP_LSB+1]),
      .no  (ir_q[COMP_LSB]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   Inc16 u_inc (
      .in  ({{(16-PC_W){1'b0}}, pc_q}),
      .out (inc_out)
   );

   hack_pc #(
      .PC_W (PC_W)
   ) u_pc (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (pc_target),
      .inc_val  (pc_next_inc),
      .pc       (pc_q)
   );

   assign pc_next_inc = inc_out[PC_W-1:0];
   assign unused_inc  = &{1'b0, inc_out[15:PC_W]};
   assign alu_y       = ir_q[A_BIT] ? m_q : a_q;
   assign jump_now    = jump_taken(ir_q[JMP_LT:JMP_GT], alu_ng, alu_zr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_target = a_q[PC_W-1:0];
      case (state_q)
         S_FETCH: begin
            if (bus.instr_valid) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!ir_q[C_BIT]) begin
               pc_inc  = 1'b1;
               state_d = S_FETCH;
            end
`ifdef HACK_EXEC_STRICT_DECODE_EN
            else if (ir_q[14:13] != 2'b11) begin
               state_d = S_HALT;
            end
`endif
            else if (ir_q[A_BIT]) begin
               state_d = S_READ;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_READ: begin
            if (bus.mem_rd_valid) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (ir_q[DEST_M]) begin
               state_d = S_WRITE;
            end else begin
               pc_load = jump_now;
               pc_inc  = ~jump_now;
               state_d = S_FETCH;
            end
         end
         S_WRITE: begin
            // addr_q still holds the pre-update A, which is the jump target
            if (bus.mem_wr_ack) begin
               pc_target = addr_q;
               pc_load   = jump_q;
               pc_inc    = ~jump_q;
               state_d   = S_FETCH;
            end
         end
`ifdef HACK_EXEC_STRICT_DECODE_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_q    <= '0;
         a_q     <= '0;
         d_q     <= '0;
         m_q     <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         jump_q  <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (bus.instr_valid) begin
                  ir_q <= bus.instr;
               end
            end
            S_DECODE: begin
               if (!ir_q[C_BIT]) begin
                  a_q <= {1'b0, ir_q[14:0]};
               end else if (state_d == S_READ) begin
                  addr_q <= a_q[PC_W-1:0];
               end
            end
            S_READ: begin
               if (bus.mem_rd_valid) begin
                  m_q <= bus.mem_rdata;
               end
            end
            S_EXEC: begin
               if (ir_q[DEST_A]) begin
                  a_q <= alu_out;
               end
               if (ir_q[DEST_D]) begin
                  d_q <= alu_out;
               end
               addr_q  <= a_q[PC_W-1:0];
               wdata_q <= alu_out;
               jump_q  <= jump_now;
            end
            default: begin
            end
         endcase
      end
   end

   // Ready is masked while in reset so the fetch side sees no spurious acceptance
   assign bus.instr_ready = (state_q == S_FETCH) && reset_n;
   assign bus.pc          = pc_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_rd      = (state_q == S_READ);
   assign bus.mem_wr      = (state_q == S_WRITE);
   assign bus.mem_wdata   = wdata_q;
   assign a_reg           = a_q;
   assign d_reg           = d_q;

`ifdef HACK_EXEC_STRICT_DECODE_EN
   assign halted = (state_q == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_exec_unit.sv
// tb/tb_hack_exec_unit.sv - scoreboard bench for hack_exec_unit
module tb_hack_exec_unit;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      logic [14:0] pc;
      int          lat;
   } rt_t;

   typedef struct {
      logic [14:0] addr;
      logic [15:0] data;
      int          len;
      logic [14:0] pc;
   } mem_t;

   logic        clk;
   logic        reset_n;
   logic [15:0] a_reg;
   logic [15:0] d_reg;
   logic        halted;

   int passed;
   int total;

   rt_t  rt_q[$];
   mem_t wr_q[$];
   mem_t rd_q[$];

   int          rd_wait;
   int          wr_wait;
   logic [15:0] rd_data;
   int          rd_cnt;
   int          wr_cnt;

   int   mon_cyc;
   int   mon_hs_cyc;
   int   mon_wr_len;
   int   mon_rd_len;
   bit   mon_pending;
   rt_t  mon_r;
   mem_t mon_m;

   hack_exec_unit_if #(.PC_W(15)) bus ();

   hack_exec_unit #(.PC_W(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master),
      .a_reg   (a_reg),
      .d_reg   (d_reg),
      .halted  (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      $display("FAIL %s: actual event/timeout required none", name);
   endtask

   // Memory responder: answers after a programmable number of wait cycles
   initial begin
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack   = 1'b0;
      bus.mem_rdata    = 16'h0000;
      rd_cnt = 0;
      wr_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!bus.mem_rd) begin
            rd_cnt = 0;
            bus.mem_rd_valid = 1'b0;
         end else if (rd_cnt == rd_wait) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rdata    = rd_data;
            rd_cnt = 0;
         end else begin
            bus.mem_rd_valid = 1'b0;
            rd_cnt++;
         end
         if (!bus.mem_wr) begin
            wr_cnt = 0;
            bus.mem_wr_ack = 1'b0;
         end else if (wr_cnt == wr_wait) begin
            bus.mem_wr_ack = 1'b1;
            wr_cnt = 0;
         end else begin
            bus.mem_wr_ack = 1'b0;
            wr_cnt++;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes a transfer or retires an instruction
   initial begin
      mon_cyc = 0;
      mon_hs_cyc = 0;
      mon_wr_len = 0;
      mon_rd_len = 0;
      mon_pending = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mon_pending = 1'b0;
            mon_wr_len  = 0;
            mon_rd_len  = 0;
         end else begin
            mon_cyc++;
            if (bus.mem_wr) begin
               mon_wr_len++;
               if (bus.mem_wr_ack) begin
                  if (wr_q.size() == 0) begin
                     note_fail("wr_unexpected");
                  end else begin
                     mon_m = wr_q.pop_front();
                     chk("wr_addr",  32'(bus.mem_addr),  32'(mon_m.addr));
                     chk("wr_data",  32'(bus.mem_wdata), 32'(mon_m.data));
                     chk("wr_hold",  32'(mon_wr_len),    32'(mon_m.len));
                     chk("wr_pc",    32'(bus.pc),        32'(mon_m.pc));
                  end
                  mon_wr_len = 0;
               end
            end else begin
               mon_wr_len = 0;
            end
            if (bus.mem_rd) begin
               mon_rd_len++;
               if (bus.mem_rd_valid) begin
                  if (rd_q.size() == 0) begin
                     note_fail("rd_unexpected");
                  end else begin
                     mon_m = rd_q.pop_front();
                     chk("rd_addr", 32'(bus.mem_addr), 32'(mon_m.addr));
                     chk("rd_hold", 32'(mon_rd_len),   32'(mon_m.len));
                     chk("rd_pc",   32'(bus.pc),       32'(mon_m.pc));
                  end
                  mon_rd_len = 0;
               end
            end else begin
               mon_rd_len = 0;
            end
            if (bus.instr_ready) begin
               if (mon_pending) begin
                  mon_pending = 1'b0;
                  if (rt_q.size() == 0) begin
                     note_fail("retire_unexpected");
                  end else begin
                     mon_r = rt_q.pop_front();
                     chk("ret_a",   32'(a_reg),  32'(mon_r.a));
                     chk("ret_d",   32'(d_reg),  32'(mon_r.d));
                     chk("ret_pc",  32'(bus.pc), 32'(mon_r.pc));
                     chk("ret_lat", 32'(mon_cyc - mon_hs_cyc), 32'(mon_r.lat));
                  end
               end
               if (bus.instr_valid) begin
                  mon_pending = 1'b1;
                  mon_hs_cyc  = mon_cyc;
               end
            end
         end
      end
   end

   task automatic do_instr(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] ed,
                           input logic [14:0] epc, input int lat);
      int n;
      rt_q.push_back('{a: ea, d: ed, pc: epc, lat: lat});
      @(posedge clk);
      #1;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      n = 0;
      while (!bus.instr_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.instr_ready) begin
         note_fail("handshake_timeout");
         bus.instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Junk word held valid while busy must be ignored
      bus.instr = 16'hFFFF;
      n = 0;
      while (!bus.instr_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.instr_ready) begin
         note_fail("retire_timeout");
      end
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      passed = 0;
      total  = 0;
      rd_wait = 0;
      wr_wait = 0;
      rd_data = 16'h0000;
      reset_n = 1'b0;
      bus.instr = 16'h0000;
      bus.instr_valid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
      chk("rst_mem_rd",      32'(bus.mem_rd),      32'd0);
      chk("rst_mem_wr",      32'(bus.mem_wr),      32'd0);
      chk("rst_mem_addr",    32'(bus.mem_addr),    32'd0);
      chk("rst_mem_wdata",   32'(bus.mem_wdata),   32'd0);
      chk("rst_pc",          32'(bus.pc),          32'd0);
      chk("rst_a",           32'(a_reg),           32'd0);
      chk("rst_d",           32'(d_reg),           32'd0);
      chk("rst_halted",      32'(halted),          32'd0);
      reset_n = 1'b1;
      #1;
      chk("ready_after_release", 32'(bus.instr_ready), 32'd1);

      do_instr(16'h0005, 16'h0005, 16'h0000, 15'h0001, 2);
      do_instr(16'h0003, 16'h0003, 16'h0000, 15'h0002, 2);
      do_instr(16'hEC10, 16'h0003, 16'h0003, 15'h0003, 3);
      do_instr(16'h0005, 16'h0005, 16'h0003, 15'h0004, 2);
      do_instr(16'hE090, 16'h0005, 16'h0008, 15'h0005, 3);
      do_instr(16'h0007, 16'h0007, 16'h0008, 15'h0006, 2);
      do_instr(16'hEC10, 16'h0007, 16'h0007, 15'h0007, 3);
      do_instr(16'h0010, 16'h0010, 16'h0007, 15'h0008, 2);

      wr_wait = 4;
      wr_q.push_back('{addr: 15'h0010, data: 16'h0007, len: 5, pc: 15'h0008});
      do_instr(16'hE308, 16'h0010, 16'h0007, 15'h0009, 8);

      do_instr(16'h0020, 16'h0020, 16'h0007, 15'h000A, 2);
      rd_wait = 2;
      rd_data = 16'h0009;
      rd_q.push_back('{addr: 15'h0020, data: 16'h0009, len: 3, pc: 15'h000A});
      do_instr(16'hFC10, 16'h0020, 16'h0009, 15'h000B, 6);

      do_instr(16'hEE90, 16'h0020, 16'hFFFF, 15'h000C, 3);
      do_instr(16'h0042, 16'h0042, 16'hFFFF, 15'h000D, 2);
      do_instr(16'hE304, 16'h0042, 16'hFFFF, 15'h0042, 3);
      do_instr(16'hEFD0, 16'h0042, 16'h0001, 15'h0043, 3);
      do_instr(16'h0042, 16'h0042, 16'h0001, 15'h0044, 2);
      do_instr(16'hE304, 16'h0042, 16'h0001, 15'h0045, 3);
      do_instr(16'hE321, 16'h0001, 16'h0001, 15'h0042, 3);

      wr_wait = 0;
      wr_q.push_back('{addr: 15'h0001, data: 16'h0001, len: 1, pc: 15'h0042});
      do_instr(16'hE309, 16'h0001, 16'h0001, 15'h0001, 4);

      rd_wait = 0;
      rd_data = 16'hABCD;
      rd_q.push_back('{addr: 15'h0001, data: 16'hABCD, len: 1, pc: 15'h0001});
      do_instr(16'hFC10, 16'h0001, 16'hABCD, 15'h0002, 4);

      do_instr(16'h7FFF, 16'h7FFF, 16'hABCD, 15'h0003, 2);
      do_instr(16'hEA87, 16'h7FFF, 16'hABCD, 15'h7FFF, 3);
      do_instr(16'h0030, 16'h0030, 16'hABCD, 15'h0000, 2);
      do_instr(16'h0031, 16'h0031, 16'hABCD, 15'h0001, 2);

      // Reset in the middle of a long write
      wr_wait = 50;
      @(posedge clk);
      #1;
      bus.instr       = 16'hE308;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midwr_mem_wr_active", 32'(bus.mem_wr), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midwr_mem_wr_drop", 32'(bus.mem_wr),      32'd0);
      chk("midwr_a",           32'(a_reg),           32'd0);
      chk("midwr_d",           32'(d_reg),           32'd0);
      chk("midwr_pc",          32'(bus.pc),          32'd0);
      chk("midwr_ready",       32'(bus.instr_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("midwr_ready_after", 32'(bus.instr_ready), 32'd1);
      wr_wait = 0;
      do_instr(16'h0005, 16'h0005, 16'h0000, 15'h0001, 2);

`ifdef HACK_EXEC_STRICT_DECODE_EN
      @(posedge clk);
      #1;
      bus.instr       = 16'h8000;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("strict_halted", 32'(halted),          32'd1);
      chk("strict_ready",  32'(bus.instr_ready), 32'd0);
      chk("strict_pc",     32'(bus.pc),          32'd1);
      chk("strict_a",      32'(a_reg),           32'd5);
`else
      chk("halted_tied", 32'(halted), 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rt_q_drained", 32'(rt_q.size()), 32'd0);
      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hack_exec_unit.md
# hack_exec_unit

Multi-cycle Hack instruction execution stage, directly downstream of the Hack ALU and 16-bit incrementer. It accepts one 16-bit Hack instruction per handshake, drives the existing `HackALU` with the decoded control bits, and consumes the ALU result and flags. It writes results back to the A/D registers and data memory, and computes the next program counter. Memory reads and writes use ready/valid handshakes, so the unit can sit in front of slow SDRAM-backed RAM on the MiSTer build.

## Interface
Parameters:
- `PC_W`, 15: program counter and data-address width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  out  PC_W  address of the instruction being requested.
- `instr`  in  16  instruction word.
- `instr_valid`  in  1  `instr` holds ROM[`pc`].
- `instr_ready`  out  1  unit will accept `instr` this cycle.
- `mem_addr`  out  PC_W  data address for a read or write.
- `mem_rd`  out  1  read request; held until `mem_rd_valid`.
- `mem_rdata`  in  16  read data (M).
- `mem_rd_valid`  in  1  `mem_rdata` valid; single-cycle pulse.
- `mem_wr`  out  1  write request; held until `mem_wr_ack`.
- `mem_wdata`  out  16  write data (outM).
- `mem_wr_ack`  in  1  write accepted.
- `a_reg`, `d_reg`  out  16  architectural A and D (debug/display).
- `halted`  out  1  strict-decode halt (0 when macro absent).

## Operation
- States: FETCH, DECODE, READ, EXEC, WRITE, HALT.
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`, latch IR → DECODE.
- DECODE:
  - A-instruction (IR[15]=0): A ← {0,IR[14:0]}, PC ← PC+1 → FETCH.
  - C-instruction with a-bit IR[12]=1: `mem_addr` ← A[14:0], assert `mem_rd` → READ.
  - Otherwise → EXEC.
- READ:
  - Hold `mem_rd` until `mem_rd_valid`.
  - Latch M → EXEC.
- EXEC: the ALU is combinational.
  - ALU x = D; ALU y = a-bit ? M : A.
  - zx, nx, zy, ny, f, no = IR[11:6].
  - Dest IR[5:3] = A, D, M; A and D update at the end of EXEC.
  - `mem_addr` and `mem_wdata` latch the **pre-update** A and the ALU out.
  - If d3: → WRITE. Else resolve PC → FETCH.
- WRITE:
  - Hold `mem_wr` until `mem_wr_ack`.
  - Then resolve PC → FETCH.
- PC resolve:
  - `jump` = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr), with j = IR[2:0].
  - PC ← `jump` ? pre-update A[14:0] : PC+1.
  - PC+1 wraps 0x7FFF → 0x0000.
- The jump flags are captured in EXEC and held through WRITE.
- Dest A with a jump: the target is the old A, per Hack semantics.
- A/D writes are 16-bit; no carry out. PC is 15-bit.

## Timing
- Reset values:
  - State FETCH; `pc`, A, D, IR = 0.
  - `instr_ready`=0 during reset and 1 on the first cycle after release.
  - `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata`, `halted` = 0.
- Reset mid-READ/WRITE: requests drop asynchronously. No partial A/D/PC update survives.
- Latency, handshake cycle to next `instr_ready`:
  - A-instr: 2 cycles.
  - C-instr, no M: 3 cycles.
  - Each READ/WRITE adds 1 + wait cycles.
- `mem_rd_valid` or `mem_wr_ack` in the request's first cycle is legal and counts; zero wait adds exactly 1 cycle.
- `mem_rd_valid`/`mem_wr_ack` outside READ/WRITE is ignored.
- `instr_valid` outside FETCH is ignored. `pc` is stable throughout FETCH.

## Configuration
- `HACK_EXEC_STRICT_DECODE_EN`:
  - Defined: a C-instruction with IR[14:13]≠2'b11 in DECODE → HALT. `halted`=1, `instr_ready`=0, no side effects; exit only by reset.
  - Undefined: IR[14:13] ignored; HALT state and `halted` logic absent, `halted` tied 0.

## Structure
- Shared package `hack_pkg`:
  - State enum.
  - IR field index constants (A_BIT, COMP_LSB, DEST_A/D/M, JMP_LT/EQ/GT).
  - `PC_W` default.
- Instantiates existing `HackALU` and `Inc16` (for PC+1); no new arithmetic.
- One natural sub-module: `hack_pc`, the 15-bit PC register with load/inc/hold and async reset.

## Test plan
- Reset then `instr`=0x0005 → 2 cycles later A=0x0005, `pc`=1, no memory activity.
- A=5, D=3, `instr`=0xE090 (D=D+A) → D=0x0008, `pc`+1, 3 cycles.
- A=0x0010, D=7, `instr`=0xE308 (M=D):
  - `mem_wr` with addr 0x0010, wdata 0x0007.
  - Held across 4-cycle ack delay.
  - `pc` updates only after ack.
- A=0x0020, M=0x0009 (`mem_rd_valid` after 2 cycles), `instr`=0xFC10 (D=M) → D=0x0009.
- Jump:
  - D=0xFFFF, A=0x0042, `instr`=0xE304 (D;JLT) → `pc`=0x0042.
  - Same with D=1 → `pc`+1.
  - `pc`=0x7FFF non-jump → 0x0000.
- Assert `reset_n`=0 mid-WRITE → `mem_wr` drops immediately, A/D/`pc`=0. With macro: `instr`=0x8000 → `halted`=1, `instr_ready` stays 0.
